// File: rtl/fft_pkg.sv
// Shared sizes, read-FSM encoding and bit-reverse helper for the FFT input path.
package fft_pkg;

   localparam int unsigned N_POINTS     = 16;
   localparam int unsigned LOG2N        = 4;
   localparam int unsigned DATA_W       = 24;
   localparam int          BITREV_MAX_W = 10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_SEND = 2'd2
   } rd_state_e;

   // Reverses the low w bits of v; w may be anything up to BITREV_MAX_W.
   function automatic logic [BITREV_MAX_W-1:0] bitrev(input logic [BITREV_MAX_W-1:0] v,
                                                       input int unsigned w);
      logic [BITREV_MAX_W-1:0] r;
      for (int i = 0; i < BITREV_MAX_W; i++) r[i] = v[BITREV_MAX_W-1-i];
      return r >> (BITREV_MAX_W - w);
   endfunction

endpackage

// File: rtl/ping_pong_ram.sv
// Two-bank sample store: one write port, one registered read port, bank = address MSB.
module ping_pong_ram #(
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned WORD_W = 48
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WORD_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WORD_W-1:0] rdata
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [WORD_W-1:0] mem_q [DEPTH];
   logic [WORD_W-1:0] rdata_q;

   // No reset here so the array and read register map onto block RAM.
   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
      rdata_q <= mem_q[raddr];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/fft_input_buffer.sv
// Collects frames into a ping-pong store at bit-reversed addresses and streams each
// completed frame to the FFT core over valid/ready.
module fft_input_buffer #(
   parameter int unsigned N_POINTS = fft_pkg::N_POINTS,
   parameter int unsigned LOG2N    = fft_pkg::LOG2N,
   parameter int unsigned DATA_W   = fft_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] in_re,
   input  logic [DATA_W-1:0] in_im,
   input  logic              in_en,
   output logic [DATA_W-1:0] out_re,
   output logic [DATA_W-1:0] out_im,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [LOG2N-1:0]  out_idx,
   output logic              out_last,
   output logic              overflow_o
);
   import fft_pkg::*;

   localparam int unsigned      WORD_W   = 2 * DATA_W;
   localparam int unsigned      ADDR_W   = LOG2N + 1;
   localparam logic [LOG2N-1:0] LAST_PTR = LOG2N'(N_POINTS - 1);

   logic [LOG2N-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic              wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
   logic [1:0]        full_q, full_d;
   rd_state_e         state_q, state_d;
   logic [DATA_W-1:0] out_re_q, out_re_d, out_im_q, out_im_d;
   logic [LOG2N-1:0]  out_idx_q, out_idx_d;
   logic              out_valid_q, out_valid_d, out_last_q, out_last_d;
   logic              overflow_q, overflow_d;
   logic              wr_accept_c, wr_done_c, rd_done_c;
   logic [ADDR_W-1:0] waddr_c, raddr_c;
   logic [WORD_W-1:0] rdata;

   function automatic logic [LOG2N-1:0] rev(input logic [LOG2N-1:0] v);
      return LOG2N'(bitrev(BITREV_MAX_W'(v), LOG2N));
   endfunction

   // Write side: a full target bank drops the sample and flags overflow.
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      wr_bank_d   = wr_bank_q;
      wr_accept_c = in_en & ~full_q[wr_bank_q];
      wr_done_c   = wr_accept_c & (wr_ptr_q == LAST_PTR);
      overflow_d  = in_en & full_q[wr_bank_q];
      waddr_c     = {wr_bank_q, rev(wr_ptr_q)};
      if (wr_done_c) begin
         wr_ptr_d  = '0;
         wr_bank_d = ~wr_bank_q;
      end else if (wr_accept_c) begin
         wr_ptr_d = wr_ptr_q + LOG2N'(1);
      end
   end

   // Read FSM; the RAM is always addressed one word ahead of what out_* will show.
   always_comb begin
      state_d     = state_q;
      rd_ptr_d    = rd_ptr_q;
      rd_bank_d   = rd_bank_q;
      out_re_d    = out_re_q;
      out_im_d    = out_im_q;
      out_idx_d   = out_idx_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      rd_done_c   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (full_q[rd_bank_q]) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            rd_ptr_d    = '0;
            out_re_d    = rdata[WORD_W-1:DATA_W];
            out_im_d    = rdata[DATA_W-1:0];
            out_idx_d   = rev('0);
            out_valid_d = 1'b1;
            out_last_d  = (LAST_PTR == '0);
            state_d     = ST_SEND;
         end
         ST_SEND: begin
            if (out_ready) begin
               if (rd_ptr_q != LAST_PTR) begin
                  rd_ptr_d   = rd_ptr_q + LOG2N'(1);
                  out_re_d   = rdata[WORD_W-1:DATA_W];
                  out_im_d   = rdata[DATA_W-1:0];
                  out_idx_d  = rev(rd_ptr_d);
                  out_last_d = (rd_ptr_d == LAST_PTR);
               end else begin
                  rd_done_c   = 1'b1;
                  rd_bank_d   = ~rd_bank_q;
                  rd_ptr_d    = '0;
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
                  state_d     = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (state_q == ST_IDLE) raddr_c = {rd_bank_q, {LOG2N{1'b0}}};
      else                    raddr_c = {rd_bank_q, rd_ptr_d + LOG2N'(1)};
   end

   // Frame completion and drain completion always address different banks.
   always_comb begin
      full_d = full_q;
      if (wr_done_c) full_d[wr_bank_q] = 1'b1;
      if (rd_done_c) full_d[rd_bank_q] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         wr_bank_q   <= 1'b0;
         rd_ptr_q    <= '0;
         rd_bank_q   <= 1'b0;
         full_q      <= '0;
         state_q     <= ST_IDLE;
         out_re_q    <= '0;
         out_im_q    <= '0;
         out_idx_q   <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         wr_bank_q   <= wr_bank_d;
         rd_ptr_q    <= rd_ptr_d;
         rd_bank_q   <= rd_bank_d;
         full_q      <= full_d;
         state_q     <= state_d;
         out_re_q    <= out_re_d;
         out_im_q    <= out_im_d;
         out_idx_q   <= out_idx_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         overflow_q  <= overflow_d;
      end
   end

   ping_pong_ram #(
      .ADDR_W (ADDR_W),
      .WORD_W (WORD_W)
   ) u_ram (
      .clk   (clk),
      .we    (wr_accept_c),
      .waddr (waddr_c),
      .wdata ({in_re, in_im}),
      .raddr (raddr_c),
      .rdata (rdata)
   );

   assign out_re     = out_re_q;
   assign out_im     = out_im_q;
   assign out_idx    = out_idx_q;
   assign out_valid  = out_valid_q;
   assign out_last   = out_last_q;
   assign overflow_o = overflow_q;

endmodule

// File: tb/tb_fft_input_buffer.sv
// Bench for fft_input_buffer: frame-level reference model plus directed and random traffic.
module tb_fft_input_buffer;
   localparam int N  = 16;
   localparam int LG = 4;
   localparam int DW = 24;

   logic          clk       = 1'b0;
   logic          rst_n     = 1'b0;
   logic [DW-1:0] in_re     = '0;
   logic [DW-1:0] in_im     = '0;
   logic          in_en     = 1'b0;
   logic          out_ready = 1'b0;
   logic [DW-1:0] out_re, out_im;
   logic          out_valid, out_last, overflow_o;
   logic [LG-1:0] out_idx;

   fft_input_buffer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_re      (in_re),
      .in_im      (in_im),
      .in_en      (in_en),
      .out_re     (out_re),
      .out_im     (out_im),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_idx    (out_idx),
      .out_last   (out_last),
      .overflow_o (overflow_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int            idx;
      logic [DW-1:0] re;
      logic [DW-1:0] im;
      bit            last;
   } item_t;

   // Reference model: completed frames become a flat queue of expected transfers.
   item_t         exp_q[$];
   item_t         it_tmp;
   logic [DW-1:0] part_re [N];
   logic [DW-1:0] part_im [N];
   int            m_cnt, m_wr_bank, m_rd_bank;
   bit            m_full [2];
   bit            exp_ovf, held;
   int            obs_idx[$];
   logic [DW-1:0] obs_re[$], obs_im[$];
   bit            obs_last[$];
   int            n_ovf_seen;
   int            n_checks = 0;
   int            n_fail   = 0;
   int            seq [N] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

   function automatic int rev_idx(input int p);
      int r = 0;
      for (int b = 0; b < LG; b++) r = r * 2 + ((p >> b) & 1);
      return r;
   endfunction

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_q.delete();
         m_cnt = 0; m_wr_bank = 0; m_rd_bank = 0;
         m_full[0] = 1'b0; m_full[1] = 1'b0;
         exp_ovf = 1'b0; held = 1'b0;
      end else begin
         exp_ovf = 1'b0;
         if (in_en) begin
            if (m_full[m_wr_bank]) begin
               exp_ovf = 1'b1;
            end else begin
               part_re[m_cnt] = in_re;
               part_im[m_cnt] = in_im;
               m_cnt++;
               if (m_cnt == N) begin
                  for (int p = 0; p < N; p++) begin
                     it_tmp.idx  = rev_idx(p);
                     it_tmp.re   = part_re[it_tmp.idx];
                     it_tmp.im   = part_im[it_tmp.idx];
                     it_tmp.last = (p == N - 1);
                     exp_q.push_back(it_tmp);
                  end
                  m_full[m_wr_bank] = 1'b1;
                  m_wr_bank ^= 1;
                  m_cnt = 0;
               end
            end
         end
         held = out_valid && !out_ready;
         if (out_valid && out_ready) begin
            obs_idx.push_back(int'(out_idx));
            obs_re.push_back(out_re);
            obs_im.push_back(out_im);
            obs_last.push_back(out_last);
            if (exp_q.size() != 0) begin
               it_tmp = exp_q.pop_front();
               if (it_tmp.last) begin
                  m_full[m_rd_bank] = 1'b0;
                  m_rd_bank ^= 1;
               end
            end
         end
      end
   end

   // Mid-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (rst_n) begin
         if (overflow_o) n_ovf_seen++;
         chk("overflow_o", overflow_o, exp_ovf);
         if (held) chk("valid_held", out_valid, 1);
         if (exp_q.size() == 0) begin
            chk("valid_idle", out_valid, 0);
         end else if (out_valid) begin
            chk("out_idx", out_idx, exp_q[0].idx);
            chk("out_re", out_re, exp_q[0].re);
            chk("out_im", out_im, exp_q[0].im);
            chk("out_last", out_last, exp_q[0].last);
         end
         if (!out_valid) chk("last_no_valid", out_last, 0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic [DW-1:0] re, input logic [DW-1:0] im);
      tick();
      in_en = 1'b1; in_re = re; in_im = im;
   endtask

   task automatic put_rand(input int n);
      for (int i = 0; i < n; i++) put(DW'($urandom), DW'($urandom));
   endtask

   task automatic stop_in();
      tick();
      in_en = 1'b0;
   endtask

   task automatic clear_obs();
      obs_idx.delete(); obs_re.delete(); obs_im.delete(); obs_last.delete();
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < budget) begin
         tick();
         n++;
      end
      chk("drain_done", (exp_q.size() == 0 && !out_valid), 1);
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_valid"}, out_valid, 0);
      chk({tag, "_last"}, out_last, 0);
      chk({tag, "_ovf"}, overflow_o, 0);
      chk({tag, "_idx"}, out_idx, 0);
      chk({tag, "_re"}, out_re, 0);
      chk({tag, "_im"}, out_im, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int ones;
      tick();
      chk_outputs_zero("reset");
      tick();
      rst_n = 1'b1;
      tick();

      // 1: ramp frame, full-rate drain, latency and order pinned by hand
      out_ready = 1'b1;
      clear_obs();
      for (int k = 0; k < N; k++) put(DW'(k << 8), DW'(-(k << 8)));
      stop_in();
      n = 0;
      while (!out_valid && n < 10) begin tick(); n++; end
      chk("t1_first_valid_latency", n, 2);
      wait_drain(100);
      chk("t1_count", obs_idx.size(), N);
      for (int i = 0; i < N && i < obs_idx.size(); i++) chk("t1_idx_seq", obs_idx[i], seq[i]);
      if (obs_re.size() > 1) begin
         chk("t1_re_idx8", obs_re[1], 24'h000800);
         chk("t1_im_idx8", obs_im[1], 24'hFFF800);
      end
      ones = 0;
      foreach (obs_last[i]) ones += int'(obs_last[i]);
      chk("t1_last_count", ones, 1);
      if (obs_last.size() == N) chk("t1_last_pos", obs_last[N-1], 1);

      // 2: backpressure 1,0,0,1 during fill and drain
      clear_obs();
      for (int i = 0; i < 80; i++) begin
         tick();
         out_ready = ((i % 4) == 0) || ((i % 4) == 3);
         in_en     = (i < N);
         in_re     = DW'($urandom);
         in_im     = DW'($urandom);
      end
      in_en = 1'b0;
      out_ready = 1'b1;
      wait_drain(100);
      chk("t2_count", obs_idx.size(), N);
      for (int i = 0; i < N && i < obs_idx.size(); i++) chk("t2_idx_seq", obs_idx[i], seq[i]);

      // 3: two back-to-back frames
      clear_obs();
      n_ovf_seen = 0;
      put_rand(2 * N);
      stop_in();
      wait_drain(200);
      chk("t3_count", obs_idx.size(), 2 * N);
      chk("t3_no_overflow", n_ovf_seen, 0);
      if (obs_idx.size() == 2 * N) begin
         chk("t3_frame2_first_idx", obs_idx[N], 0);
         chk("t3_frame2_last", obs_last[2*N-1], 1);
      end

      // 4: both banks full, 33rd sample dropped
      clear_obs();
      n_ovf_seen = 0;
      out_ready = 1'b0;
      put_rand(2 * N + 1);
      stop_in();
      repeat (4) tick();
      chk("t4_one_overflow", n_ovf_seen, 1);
      out_ready = 1'b1;
      wait_drain(200);
      chk("t4_count", obs_idx.size(), 2 * N);

      // 5a: reset at sample 7 of a frame
      put_rand(7);
      stop_in();
      rst_n = 1'b0;
      #1;
      chk_outputs_zero("t5a");
      tick();
      rst_n = 1'b1;
      clear_obs();
      put_rand(N);
      stop_in();
      wait_drain(100);
      chk("t5a_count", obs_idx.size(), N);
      if (obs_idx.size() != 0) chk("t5a_first_idx", obs_idx[0], 0);

      // 5b: reset mid-drain
      out_ready = 1'b0;
      put_rand(N);
      stop_in();
      repeat (4) tick();
      chk("t5b_valid_before_reset", out_valid, 1);
      out_ready = 1'b1;
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      chk_outputs_zero("t5b");
      tick();
      rst_n = 1'b1;
      clear_obs();
      put_rand(N);
      stop_in();
      wait_drain(100);
      chk("t5b_count", obs_idx.size(), N);
      if (obs_idx.size() != 0) chk("t5b_first_idx", obs_idx[0], 0);

      // random traffic and backpressure
      for (int i = 0; i < 1200; i++) begin
         tick();
         in_en     = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         in_re     = DW'($urandom);
         in_im     = DW'($urandom);
      end
      in_en = 1'b0;
      out_ready = 1'b1;
      wait_drain(300);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
